pe_group_streamer: RTL and testbench
====================================

Name: pe_group_streamer

Overview:
Transmit-side companion of the PE group: holds one tile of operands and drives the group's three receive streams (weight, input, partial-sum) over valid/rdy.
- Host loads 4 weights, 7 inputs and 4 partial sums through a register-write port, then pulses Start.
- Block streams each operand class in address order, each channel independently flow-controlled by the group's Rdy.
- Pulses Done once every word has been accepted.

Parameters:
DataWidth, 32, operand word width
W_Size, 4, weights per tile (matches W_PEGroupSize)
O_Size, 4, partial sums per tile (matches O_PEGroupSize)
I_Size, 7, inputs per tile (W_Size + O_Size - 1)
CntWidth, 3, channel counter width (clog2(I_Size+1))

Ports:
clk  in  1  clock
rst  in  1  reset
CfgWrEn  in  1  host buffer write strobe
CfgWrSel  in  2  0=W buffer, 1=I buffer, 2=O buffer, 3=ignored
CfgWrAddr  in  3  word index within selected buffer
CfgWrData  in  DataWidth  write data
Start  in  1  begin streaming loaded tile
Busy  out  1  high from Start acceptance until Done
Done  out  1  one-cycle completion pulse
W_DataOutValid  out  1  weight stream valid
W_DataOutRdy  in  1  weight stream ready
W_DataOut  out  DataWidth  weight word
I_DataOutValid  out  1  input stream valid
I_DataOutRdy  in  1  input stream ready
I_DataOut  out  DataWidth  input word
O_DataOutValid  out  1  partial-sum stream valid
O_DataOutRdy  in  1  partial-sum stream ready
O_DataOut  out  DataWidth  partial-sum word
StallCount  out  16  stall cycles (optional feature)

Interface: one clock, clk; reset rst is synchronous, active-high.

Behaviour:
- Reset: FSM=IDLE; all counters 0; all buffers 0; Busy, Done, all *Valid = 0; StallCount = 0.
- FSM states: IDLE -> STREAM -> FIN -> IDLE.
- IDLE, buffer writes:
  - CfgWrEn writes buf[CfgWrSel][CfgWrAddr] at the clock edge.
  - Address >= channel size, or Sel=3: write dropped, no error.
- IDLE, Start: at the edge, counters cleared and FSM -> STREAM; Busy=1 from the next cycle.
- STREAM, per-channel stream (W, I, O identical):
  - Valid = (cnt < Size).
  - Data = buf[cnt], combinational from the buffer.
  - Handshake = Valid & Rdy; cnt increments on handshake.
  - Valid never deasserts before its handshake; Data stays stable while Valid & !Rdy.
  - Back-to-back: one word per cycle per channel when Rdy is held high.
  - Channels are independent; a stall on one never blocks the others.
- STREAM exit: when all three counters equal Size (including the same cycle the last handshakes occur), FSM -> FIN at the next edge.
  - Minimum STREAM duration is I_Size = 7 cycles.
- FIN: Done=1 and Busy=1 for exactly one cycle; all Valid=0; then IDLE, Busy=0.
  - Start-to-Done minimum: Start at edge 0, Done high in cycle 8.
- Lockout:
  - CfgWrEn is ignored in STREAM and FIN; buffer contents are frozen.
  - Start is ignored while Busy.
  - Start and CfgWrEn together in IDLE: the write lands and Start is accepted; the streamed value at that address is the newly written one.
- Reset mid-STREAM: all Valid low in the cycle after the edge; partial transfer abandoned; buffers cleared.
- Rdy asserted while Valid=0: no effect.

Optional Feature:
- Macro STREAMER_STALL_CNT_EN.
- Defined: StallCount increments (saturating at 16'hFFFF) on every STREAM cycle in which any channel has Valid=1 & Rdy=0; cleared when Start is accepted; holds its value in IDLE.
- Undefined: StallCount tied to 0 and no counter logic is synthesized.

Decomposition:
- Package pe_stream_pkg:
  - CfgWrSel encodings (SEL_W, SEL_I, SEL_O).
  - Default sizes W_SIZE/O_SIZE/I_SIZE.
  - FSM state typedef/localparams (ST_IDLE, ST_STREAM, ST_FIN).
- Sub-module stream_channel, instantiated three times:
  - Contents: buffer array, counter, Valid/Data generation, write decode.
  - Parameterized by depth; exposes a `fin` flag (cnt==Size).

Test Plan:
- Load W=1..4, I=10..16, O=100..103; Start; all Rdy tied 1 -> each stream emits its values in order on consecutive cycles; W/O valid for 4 cycles, I for 7; Done pulses in cycle 8 after Start.
- Same load; W_DataOutRdy toggles 1,0,1,0 -> W_DataOut held stable during the 0 cycles; I/O finish unaffected; Done follows the 4th W handshake by one cycle.
- During STREAM: CfgWrEn with Sel=0, Addr=0, Data=99, plus a second Start -> stream still shows 1 at index 0 and the Start is ignored; after Done, a new Start streams 1 again.
- Assert rst after the 3rd I handshake -> next cycle all Valid=0, Busy=0; a fresh Start (no load) streams all zeros.
- CfgWrAddr=5 with Sel=0 (W), and Sel=3 -> no buffer changes; the streamed tile equals the prior load.
- With STREAMER_STALL_CNT_EN: O_DataOutRdy held 0 for 5 cycles, others 1 -> StallCount=5 at Done; without the macro -> StallCount=0.

Source files
------------

// File: rtl/pe_stream_pkg.sv
// Shared encodings and default tile geometry for the PE-group transmit streamer.
package pe_stream_pkg;

  localparam int W_SIZE  = 4;
  localparam int O_SIZE  = 4;
  localparam int I_SIZE  = W_SIZE + O_SIZE - 1;
  localparam int NUM_CH  = 3;
  localparam int STALL_W = 16;

  typedef enum logic [1:0] {
    SEL_W    = 2'd0,
    SEL_I    = 2'd1,
    SEL_O    = 2'd2,
    SEL_NONE = 2'd3
  } cfgSel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FIN    = 2'd2
  } state_e;

  // Channel index 0/1/2 maps to the W/I/O buffer select code.
  function automatic cfgSel_e chanSel(input int c);
    case (c)
      0:       return SEL_W;
      1:       return SEL_I;
      default: return SEL_O;
    endcase
  endfunction

endpackage

// File: rtl/stream_channel.sv
// One operand stream: host-loaded word buffer drained in address order over valid/rdy.
module stream_channel
  import pe_stream_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Depth     = 4,
  parameter int CntWidth  = 3,
  parameter int AddrW     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 active,
  input  logic                 wrEn,
  input  logic [AddrW-1:0]     wrAddr,
  input  logic [DataWidth-1:0] wrData,
  input  logic                 rdy,
  output logic                 valid,
  output logic [DataWidth-1:0] data,
  output logic                 fin,
  output logic                 lastHs
);

  localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [DataWidth-1:0] mem [Depth];
  logic [CntWidth-1:0]  cnt;
  logic                 inRange;
  logic                 wrHit;
  logic                 hs;
  logic [IdxW-1:0]      rdIdx;

  assign inRange = int'(cnt) < Depth;
  assign wrHit   = wrEn && (int'(wrAddr) < Depth);
  assign valid   = active && inRange;
  assign hs      = valid && rdy;
  // Park the read index at 0 once drained so the mux never sees an out-of-range address.
  assign rdIdx   = inRange ? cnt[IdxW-1:0] : '0;
  assign data    = mem[rdIdx];
  assign fin     = int'(cnt) == Depth;
  assign lastHs  = hs && (int'(cnt) == Depth - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else begin
      if (wrHit) mem[wrAddr[IdxW-1:0]] <= wrData;
      if (clr)     cnt <= '0;
      else if (hs) cnt <= cnt + CntWidth'(1);
    end
  end

endmodule

// File: rtl/pe_group_streamer.sv
// Drives the PE group's W/I/O receive streams from a host-loaded tile.
// Optional stall counter enabled by defining STREAMER_STALL_CNT_EN.
module pe_group_streamer
  import pe_stream_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int W_Size    = W_SIZE,
  parameter int O_Size    = O_SIZE,
  parameter int I_Size    = W_Size + O_Size - 1,
  parameter int CntWidth  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 CfgWrEn,
  input  logic [1:0]           CfgWrSel,
  input  logic [2:0]           CfgWrAddr,
  input  logic [DataWidth-1:0] CfgWrData,
  input  logic                 Start,
  output logic                 Busy,
  output logic                 Done,
  output logic                 W_DataOutValid,
  input  logic                 W_DataOutRdy,
  output logic [DataWidth-1:0] W_DataOut,
  output logic                 I_DataOutValid,
  input  logic                 I_DataOutRdy,
  output logic [DataWidth-1:0] I_DataOut,
  output logic                 O_DataOutValid,
  input  logic                 O_DataOutRdy,
  output logic [DataWidth-1:0] O_DataOut,
  output logic [15:0]          StallCount
);

  state_e state, stateNext;
  logic   startAcc;
  logic   active;
  logic   allDone;

  logic [NUM_CH-1:0]                chValid, chRdy, chFin, chLastHs, chWrEn;
  logic [NUM_CH-1:0][DataWidth-1:0] chData;

  assign active  = state == ST_STREAM;
  assign chRdy   = {O_DataOutRdy, I_DataOutRdy, W_DataOutRdy};
  // A channel counts as finished if it already is, or its last word is taken this cycle.
  assign allDone = &(chFin | chLastHs);

  for (genvar c = 0; c < NUM_CH; c++) begin : gCh
    localparam int Depth = (c == 0) ? W_Size : (c == 1) ? I_Size : O_Size;

    assign chWrEn[c] = CfgWrEn && (state == ST_IDLE) && (CfgWrSel == chanSel(c));

    stream_channel #(
      .DataWidth(DataWidth),
      .Depth    (Depth),
      .CntWidth (CntWidth),
      .AddrW    (3)
    ) uCh (
      .clk   (clk),
      .rst   (rst),
      .clr   (startAcc),
      .active(active),
      .wrEn  (chWrEn[c]),
      .wrAddr(CfgWrAddr),
      .wrData(CfgWrData),
      .rdy   (chRdy[c]),
      .valid (chValid[c]),
      .data  (chData[c]),
      .fin   (chFin[c]),
      .lastHs(chLastHs[c])
    );
  end

  assign W_DataOutValid = chValid[0];
  assign I_DataOutValid = chValid[1];
  assign O_DataOutValid = chValid[2];
  assign W_DataOut      = chData[0];
  assign I_DataOut      = chData[1];
  assign O_DataOut      = chData[2];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    startAcc  = 1'b0;
    case (state)
      ST_IDLE: if (Start) begin
        startAcc  = 1'b1;
        stateNext = ST_STREAM;
      end
      ST_STREAM: if (allDone) stateNext = ST_FIN;
      ST_FIN:    stateNext = ST_IDLE;
      default:   stateNext = ST_IDLE;
    endcase
  end

  assign Busy = state != ST_IDLE;
  assign Done = state == ST_FIN;

`ifdef STREAMER_STALL_CNT_EN
  logic [STALL_W-1:0] stallCnt;
  logic               stall;

  assign stall = |(chValid & ~chRdy);

  always_ff @(posedge clk) begin
    if (rst)                                   stallCnt <= '0;
    else if (startAcc)                         stallCnt <= '0;
    else if (stall && (stallCnt != '1))        stallCnt <= stallCnt + STALL_W'(1);
  end

  assign StallCount = stallCnt;
`else
  assign StallCount = '0;
`endif

endmodule

// File: tb/tb_pe_group_streamer.sv
// Directed scoreboard bench for pe_group_streamer: per-channel expected-word queues.
module tb_pe_group_streamer;

  logic        clk, rst;
  logic        CfgWrEn, Start;
  logic [1:0]  CfgWrSel;
  logic [2:0]  CfgWrAddr;
  logic [31:0] CfgWrData;
  logic        Busy, Done;
  logic        W_DataOutValid, W_DataOutRdy, I_DataOutValid, I_DataOutRdy;
  logic        O_DataOutValid, O_DataOutRdy;
  logic [31:0] W_DataOut, I_DataOut, O_DataOut;
  logic [15:0] StallCount;

  int checks, failures;
  int iHs;
  bit wStallPrev, oStallPrev;
  logic [31:0] wq[$], iq[$], oq[$];
  logic [31:0] wM[4], iM[7], oM[4];

  pe_group_streamer dut (
    .clk(clk), .rst(rst),
    .CfgWrEn(CfgWrEn), .CfgWrSel(CfgWrSel), .CfgWrAddr(CfgWrAddr), .CfgWrData(CfgWrData),
    .Start(Start), .Busy(Busy), .Done(Done),
    .W_DataOutValid(W_DataOutValid), .W_DataOutRdy(W_DataOutRdy), .W_DataOut(W_DataOut),
    .I_DataOutValid(I_DataOutValid), .I_DataOutRdy(I_DataOutRdy), .I_DataOut(I_DataOut),
    .O_DataOutValid(O_DataOutValid), .O_DataOutRdy(O_DataOutRdy), .O_DataOut(O_DataOut),
    .StallCount(StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop and compare on every handshake; stalled words must show the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (wStallPrev) chk("w_valid_hold", W_DataOutValid, 1);
      if (oStallPrev) chk("o_valid_hold", O_DataOutValid, 1);
      if (W_DataOutValid && W_DataOutRdy) begin
        if (wq.size() == 0) chk("w_extra", 1, 0); else chk("w_data", W_DataOut, wq.pop_front());
      end else if (W_DataOutValid && wq.size() != 0) chk("w_hold", W_DataOut, wq[0]);
      if (I_DataOutValid && I_DataOutRdy) begin
        iHs++;
        if (iq.size() == 0) chk("i_extra", 1, 0); else chk("i_data", I_DataOut, iq.pop_front());
      end
      if (O_DataOutValid && O_DataOutRdy) begin
        if (oq.size() == 0) chk("o_extra", 1, 0); else chk("o_data", O_DataOut, oq.pop_front());
      end else if (O_DataOutValid && oq.size() != 0) chk("o_hold", O_DataOut, oq[0]);
      wStallPrev = W_DataOutValid && !W_DataOutRdy;
      oStallPrev = O_DataOutValid && !O_DataOutRdy;
    end else begin
      wStallPrev = 1'b0;
      oStallPrev = 1'b0;
    end
  end

  task automatic wr(input logic [1:0] sel, input logic [2:0] addr, input logic [31:0] data);
    CfgWrEn = 1'b1; CfgWrSel = sel; CfgWrAddr = addr; CfgWrData = data;
    if (sel == 2'd0 && addr < 3'd4) wM[addr[1:0]] = data;
    if (sel == 2'd1 && addr < 3'd7) iM[addr] = data;
    if (sel == 2'd2 && addr < 3'd4) oM[addr[1:0]] = data;
    tick();
    CfgWrEn = 1'b0;
  endtask

  task automatic loadTile();
    for (int k = 0; k < 4; k++) wr(2'd0, 3'(k), 32'(k + 1));
    for (int k = 0; k < 7; k++) wr(2'd1, 3'(k), 32'(k + 10));
    for (int k = 0; k < 4; k++) wr(2'd2, 3'(k), 32'(k + 100));
  endtask

  task automatic pushTile();
    foreach (wM[k]) wq.push_back(wM[k]);
    foreach (iM[k]) iq.push_back(iM[k]);
    foreach (oM[k]) oq.push_back(oM[k]);
  endtask

  // wPat: 0 = W ready always, 1 = ready on odd cycles, 2 = ready from cycle 3 on.
  task automatic runTile(input string tag, input int wPat, input int oStall, input bit inject,
                         input bit wrStart, input int expDone, input int expStall);
    int cyc;
    if (wrStart) begin
      CfgWrEn = 1'b1; CfgWrSel = 2'd0; CfgWrAddr = 3'd3; CfgWrData = 32'h55;
      wM[3] = 32'h55;
    end
    pushTile();
    Start = 1'b1;
    tick();
    Start = 1'b0; CfgWrEn = 1'b0;
    cyc = 1;
    chk({tag, "_busy_start"}, Busy, 1);
    while (cyc < 100) begin
      W_DataOutRdy = (wPat == 0) ? 1'b1 : (wPat == 1) ? cyc[0] : (cyc > 2);
      O_DataOutRdy = cyc > oStall;
      I_DataOutRdy = 1'b1;
      if (inject) begin
        CfgWrEn = (cyc == 1); Start = (cyc == 1);
        CfgWrSel = 2'd0; CfgWrAddr = 3'd0; CfgWrData = 32'd99;
      end
      if (Done) break;
      tick();
      cyc++;
    end
    CfgWrEn = 1'b0; Start = 1'b0;
    chk({tag, "_done_cycle"}, cyc, expDone);
    chk({tag, "_busy_at_done"}, Busy, 1);
    chk({tag, "_valid_at_done"}, {W_DataOutValid, I_DataOutValid, O_DataOutValid}, 0);
`ifdef STREAMER_STALL_CNT_EN
    chk({tag, "_stall"}, StallCount, expStall);
`else
    chk({tag, "_stall"}, StallCount, expStall * 0);
`endif
    tick();
    chk({tag, "_done_pulse"}, Done, 0);
    chk({tag, "_busy_end"}, Busy, 0);
    chk({tag, "_queues_drained"}, wq.size() + iq.size() + oq.size(), 0);
    W_DataOutRdy = 1'b1; I_DataOutRdy = 1'b1; O_DataOutRdy = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0; iHs = 0;
    foreach (wM[k]) wM[k] = '0;
    foreach (iM[k]) iM[k] = '0;
    foreach (oM[k]) oM[k] = '0;
    rst = 1'b1; CfgWrEn = 1'b0; Start = 1'b0;
    CfgWrSel = '0; CfgWrAddr = '0; CfgWrData = '0;
    W_DataOutRdy = 1'b1; I_DataOutRdy = 1'b1; O_DataOutRdy = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_valid", {W_DataOutValid, I_DataOutValid, O_DataOutValid}, 0);
    chk("rst_stall", StallCount, 0);

    loadTile();
    runTile("basic", 0, 0, 0, 0, 8, 0);
    runTile("wtoggle", 1, 0, 0, 0, 8, 3);
    runTile("lockout", 2, 0, 1, 0, 8, 2);
    runTile("rerun", 0, 0, 0, 0, 8, 0);

    // Reset in the middle of a stream abandons it and clears the buffers.
    pushTile();
    iHs = 0;
    Start = 1'b1; tick(); Start = 1'b0;
    for (int k = 0; k < 20 && iHs < 3; k++) tick();
    chk("rst_mid_wait", iHs, 3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_valid", {W_DataOutValid, I_DataOutValid, O_DataOutValid}, 0);
    chk("rst_mid_busy", Busy, 0);
    wq.delete(); iq.delete(); oq.delete();
    foreach (wM[k]) wM[k] = '0;
    foreach (iM[k]) iM[k] = '0;
    foreach (oM[k]) oM[k] = '0;
    runTile("zeros", 0, 0, 0, 0, 8, 0);

    loadTile();
    wr(2'd0, 3'd5, 32'hDEAD);
    wr(2'd3, 3'd0, 32'hBEEF);
    wr(2'd1, 3'd7, 32'hCAFE);
    wr(2'd2, 3'd4, 32'hF00D);
    runTile("dropwr", 0, 0, 0, 0, 8, 0);
    runTile("ostall", 0, 5, 0, 1, 10, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
